mcpu_core_scoreboard: RTL and testbench

//  Parametrised hazard scoreboard between decode and writeback. Tracks in-flight writes
//  to GPRs and predicates using per-entry pending counters rather than single bits, so

---
 rtl/mcpu_core_scoreboard_if.sv | 39 +++
 rtl/mcpu_core_scoreboard.sv | 141 ++++++++++++++
 tb/tb_mcpu_core_scoreboard.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_scoreboard_if.sv
// Decode / writeback / flush bundle for the core hazard scoreboard.
// The master side (decode, writeback, PC unit) drives the requests; the
// scoreboard (slave) returns the pending-write vectors and status.
interface mcpu_core_scoreboard_if #(
   parameter int NREGS  = 32,
   parameter int NPREDS = 3,
   parameter int NWB    = 2
);
   localparam int RN_W = $clog2(NREGS);

   logic                  d2sb_issue;
   logic                  d2sb_rd_we;
   logic [RN_W-1:0]       d2sb_rd_num;
   logic                  d2sb_pred_we;
   logic [1:0]            d2sb_pred_num;
   logic [NWB-1:0]        wb2sb_rd_valid;
   logic [NWB*RN_W-1:0]   wb2sb_rd_num;
   logic [NWB-1:0]        wb2sb_pred_valid;
   logic [NWB*2-1:0]      wb2sb_pred_num;
   logic                  pc2sb_flush;
   logic [NREGS-1:0]      sb2d_reg_scoreboard;
   logic [NPREDS-1:0]     sb2d_pred_scoreboard;
   logic                  sb2d_full;
   logic                  sb2d_err;

   modport master (
      output d2sb_issue, d2sb_rd_we, d2sb_rd_num, d2sb_pred_we, d2sb_pred_num,
      output wb2sb_rd_valid, wb2sb_rd_num, wb2sb_pred_valid, wb2sb_pred_num,
      output pc2sb_flush,
      input  sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb2d_full, sb2d_err
   );

   modport slave (
      input  d2sb_issue, d2sb_rd_we, d2sb_rd_num, d2sb_pred_we, d2sb_pred_num,
      input  wb2sb_rd_valid, wb2sb_rd_num, wb2sb_pred_valid, wb2sb_pred_num,
      input  pc2sb_flush,
      output sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb2d_full, sb2d_err
   );
endinterface

// File: rtl/mcpu_core_scoreboard.sv
// Hazard scoreboard between decode and writeback. Each GPR and writable
// predicate owns a small pending-write counter so that several writes to the
// same destination can be in flight. Busy bits are registered alongside the
// counters; sb2d_full is a combinational lookahead on the current request.
module mcpu_core_scoreboard #(
   parameter int NREGS  = 32,
   parameter int NPREDS = 3,
   parameter int CNT_W  = 2,
   parameter int NWB    = 2
) (
   input logic                   clkrst_core_clk,
   input logic                   clkrst_core_rst,
   mcpu_core_scoreboard_if.slave sb
);
   localparam int RN_W = $clog2(NREGS);
   localparam int PN_W = 2;
   localparam int DW   = $clog2(NWB + 1);
   localparam int SW   = CNT_W + DW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] reg_cnt       [NREGS];
   logic [CNT_W-1:0] reg_cnt_next  [NREGS];
   logic [CNT_W+1:0] reg_res       [NREGS];
   logic [CNT_W-1:0] pred_cnt      [NPREDS];
   logic [CNT_W-1:0] pred_cnt_next [NPREDS];
   logic [CNT_W+1:0] pred_res      [NPREDS];
   logic [NREGS-1:0]  reg_busy_next;
   logic [NPREDS-1:0] pred_busy_next;
   logic              step_err;
   logic              full;

   // One counter update: {overflow, underflow, next_count}. A saturated
   // counter drops the increment; more retires than pending clamps at zero.
   function automatic logic [CNT_W+1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic [DW-1:0] dec);
      logic             ovf;
      logic             unf;
      logic [SW-1:0]    up;
      logic [CNT_W-1:0] res;
      ovf = inc & (cnt == CNT_MAX);
      up  = SW'(cnt) + SW'(inc & ~ovf);
      if (SW'(dec) > up) begin
         unf = 1'b1;
         res = {CNT_W{1'b0}};
      end else begin
         unf = 1'b0;
         res = CNT_W'(up - SW'(dec));
      end
      return {ovf, unf, res};
   endfunction

   // Number of retire ports naming entry e this cycle.
   function automatic logic [DW-1:0] hits(input logic [NWB-1:0] valid,
                                          input logic [NWB*RN_W-1:0] nums,
                                          input int w, input int e);
      logic [DW-1:0] n;
      n = {DW{1'b0}};
      for (int p = 0; p < NWB; p++) begin
         if (valid[p] && (nums[p*RN_W +: RN_W] & RN_W'((1 << w) - 1)) == RN_W'(e)) begin
            n = n + DW'(1);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Next counter value, busy bit and error contribution for every entry.
   always_comb begin
      step_err = 1'b0;
      for (int e = 0; e < NREGS; e++) begin
         reg_res[e] = cnt_step(reg_cnt[e],
                               sb.d2sb_issue & sb.d2sb_rd_we & (sb.d2sb_rd_num == RN_W'(e)),
                               hits(sb.wb2sb_rd_valid, sb.wb2sb_rd_num, RN_W, e));
         reg_cnt_next[e]  = reg_res[e][CNT_W-1:0];
         reg_busy_next[e] = (reg_res[e][CNT_W-1:0] != {CNT_W{1'b0}});
         step_err = step_err | reg_res[e][CNT_W+1] | reg_res[e][CNT_W];
      end
      for (int e = 0; e < NPREDS; e++) begin
         pred_res[e] = cnt_step(pred_cnt[e],
                                sb.d2sb_issue & sb.d2sb_pred_we & (sb.d2sb_pred_num == PN_W'(e)),
                                hits(sb.wb2sb_pred_valid,
                                     {{(NWB*(RN_W-PN_W)){1'b0}}, sb.wb2sb_pred_num}, PN_W, e) & DW'(0)
                                | pred_hits(e));
         pred_cnt_next[e]  = pred_res[e][CNT_W-1:0];
         pred_busy_next[e] = (pred_res[e][CNT_W-1:0] != {CNT_W{1'b0}});
         step_err = step_err | pred_res[e][CNT_W+1] | pred_res[e][CNT_W];
      end
   end

   // Retire hits for predicate entry e, using the 2-bit predicate fields.
   function automatic logic [DW-1:0] pred_hits(input int e);
      logic [DW-1:0] n;
      n = {DW{1'b0}};
      for (int p = 0; p < NWB; p++) begin
         if (sb.wb2sb_pred_valid[p] && sb.wb2sb_pred_num[p*PN_W +: PN_W] == PN_W'(e)) begin
            n = n + DW'(1);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Saturation lookahead on the entry decode is targeting, issue or not.
   always_comb begin
      full = 1'b0;
      for (int e = 0; e < NREGS; e++) begin
         full = full | (sb.d2sb_rd_we & (sb.d2sb_rd_num == RN_W'(e)) & (reg_cnt[e] == CNT_MAX));
      end
      for (int e = 0; e < NPREDS; e++) begin
         full = full | (sb.d2sb_pred_we & (sb.d2sb_pred_num == PN_W'(e)) & (pred_cnt[e] == CNT_MAX));
      end
   end

   assign sb.sb2d_full = full;

   // Counter/busy state: async clear, flush discards in-flight writes, error is sticky.
   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         for (int e = 0; e < NREGS; e++)  reg_cnt[e]  <= {CNT_W{1'b0}};
         for (int e = 0; e < NPREDS; e++) pred_cnt[e] <= {CNT_W{1'b0}};
         sb.sb2d_reg_scoreboard  <= {NREGS{1'b0}};
         sb.sb2d_pred_scoreboard <= {NPREDS{1'b0}};
         sb.sb2d_err             <= 1'b0;
      end else if (sb.pc2sb_flush) begin
         for (int e = 0; e < NREGS; e++)  reg_cnt[e]  <= {CNT_W{1'b0}};
         for (int e = 0; e < NPREDS; e++) pred_cnt[e] <= {CNT_W{1'b0}};
         sb.sb2d_reg_scoreboard  <= {NREGS{1'b0}};
         sb.sb2d_pred_scoreboard <= {NPREDS{1'b0}};
         sb.sb2d_err             <= sb.sb2d_err;
      end else begin
         for (int e = 0; e < NREGS; e++)  reg_cnt[e]  <= reg_cnt_next[e];
         for (int e = 0; e < NPREDS; e++) pred_cnt[e] <= pred_cnt_next[e];
         sb.sb2d_reg_scoreboard  <= reg_busy_next;
         sb.sb2d_pred_scoreboard <= pred_busy_next;
         sb.sb2d_err             <= sb.sb2d_err | step_err;
      end
   end
endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
// Scoreboard-style bench for mcpu_core_scoreboard: the driver issues one
// request per cycle and queues the expected outputs from a count-based
// reference model; an independent monitor pops and compares them.
module tb_mcpu_core_scoreboard;
   localparam int NREGS  = 32;
   localparam int NPREDS = 3;
   localparam int CNT_W  = 2;
   localparam int NWB    = 2;
   localparam int RN_W   = $clog2(NREGS);
   localparam int MAXC   = (1 << CNT_W) - 1;

   typedef struct {
      logic              full;
      logic [NREGS-1:0]  rsb;
      logic [NPREDS-1:0] psb;
      logic              err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   rc[NREGS];
   int   pc[NPREDS];
   logic merr = 1'b0;

   mcpu_core_scoreboard_if #(.NREGS(NREGS), .NPREDS(NPREDS), .NWB(NWB)) sbif ();

   mcpu_core_scoreboard #(.NREGS(NREGS), .NPREDS(NPREDS), .CNT_W(CNT_W), .NWB(NWB)) dut (
      .clkrst_core_clk (clk),
      .clkrst_core_rst (rst),
      .sb              (sbif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      sbif.d2sb_issue = 1'b0;       sbif.d2sb_rd_we = 1'b0;
      sbif.d2sb_rd_num = '0;        sbif.d2sb_pred_we = 1'b0;
      sbif.d2sb_pred_num = 2'd0;    sbif.wb2sb_rd_valid = '0;
      sbif.wb2sb_rd_num = '0;       sbif.wb2sb_pred_valid = '0;
      sbif.wb2sb_pred_num = '0;     sbif.pc2sb_flush = 1'b0;
   endtask

   task automatic model_clear();
      for (int r = 0; r < NREGS; r++)  rc[r] = 0;
      for (int p = 0; p < NPREDS; p++) pc[p] = 0;
   endtask

   // One cycle of stimulus plus the model's view of what it must produce.
   task automatic step(input logic issue, input logic rd_we, input int rd_num,
                       input logic pred_we, input int pred_num,
                       input logic [1:0] wv, input int wn0, input int wn1,
                       input logic [1:0] pv, input int pn0, input int pn1,
                       input logic flush);
      exp_t e;
      int   wn[2];
      int   pn[2];
      wn[0] = wn0; wn[1] = wn1; pn[0] = pn0; pn[1] = pn1;
      @(negedge clk);
      sbif.d2sb_issue       = issue;
      sbif.d2sb_rd_we       = rd_we;
      sbif.d2sb_rd_num      = RN_W'(rd_num);
      sbif.d2sb_pred_we     = pred_we;
      sbif.d2sb_pred_num    = 2'(pred_num);
      sbif.wb2sb_rd_valid   = wv;
      sbif.wb2sb_rd_num     = {RN_W'(wn1), RN_W'(wn0)};
      sbif.wb2sb_pred_valid = pv;
      sbif.wb2sb_pred_num   = {2'(pn1), 2'(pn0)};
      sbif.pc2sb_flush      = flush;
      e.full = rd_we && rc[rd_num] == MAXC;
      if (pred_we && pred_num < NPREDS) begin
         if (pc[pred_num] == MAXC) e.full = 1'b1;
      end
      if (flush) begin
         model_clear();
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            int v;
            v = rc[r];
            if (issue && rd_we && rd_num == r) begin
               if (v == MAXC) merr = 1'b1;
               else v = v + 1;
            end
            for (int p = 0; p < 2; p++) if (wv[p] && wn[p] == r) v = v - 1;
            if (v < 0) begin merr = 1'b1; v = 0; end
            rc[r] = v;
         end
         for (int r = 0; r < NPREDS; r++) begin
            int v;
            v = pc[r];
            if (issue && pred_we && pred_num == r) begin
               if (v == MAXC) merr = 1'b1;
               else v = v + 1;
            end
            for (int p = 0; p < 2; p++) if (pv[p] && pn[p] == r) v = v - 1;
            if (v < 0) begin merr = 1'b1; v = 0; end
            pc[r] = v;
         end
      end
      for (int r = 0; r < NREGS; r++)  e.rsb[r] = (rc[r] != 0);
      for (int r = 0; r < NPREDS; r++) e.psb[r] = (pc[r] != 0);
      e.err = merr;
      q.push_back(e);
   endtask

   task automatic idle();            step(1'b0,1'b0,0,1'b0,0,2'b00,0,0,2'b00,0,0,1'b0); endtask
   task automatic iss_r(input int n); step(1'b1,1'b1,n,1'b0,0,2'b00,0,0,2'b00,0,0,1'b0); endtask
   task automatic ret_r(input int n); step(1'b0,1'b0,0,1'b0,0,2'b01,n,0,2'b00,0,0,1'b0); endtask
   task automatic iss_p(input int n); step(1'b1,1'b0,0,1'b1,n,2'b00,0,0,2'b00,0,0,1'b0); endtask
   task automatic ret_p(input int n); step(1'b0,1'b0,0,1'b0,0,2'b00,0,0,2'b01,n,0,1'b0); endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain queue_left=%0d expected=0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   // Asynchronous reset mid-operation, with an issue to r5 held during reset.
   task automatic do_reset();
      drain();
      #3;
      rst = 1'b1;
      sbif.d2sb_issue = 1'b1; sbif.d2sb_rd_we = 1'b1; sbif.d2sb_rd_num = RN_W'(5);
      #1;
      chk("rst_async_reg_sb", 64'(sbif.sb2d_reg_scoreboard), 64'd0);
      chk("rst_async_pred_sb", 64'(sbif.sb2d_pred_scoreboard), 64'd0);
      chk("rst_async_err", 64'(sbif.sb2d_err), 64'd0);
      repeat (2) @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      model_clear();
      merr = 1'b0;
   endtask

   // Monitor: full is sampled mid-cycle, registered outputs just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("full", 64'(sbif.sb2d_full), 64'(e.full));
            @(posedge clk);
            #1;
            chk("reg_scoreboard", 64'(sbif.sb2d_reg_scoreboard), 64'(e.rsb));
            chk("pred_scoreboard", 64'(sbif.sb2d_pred_scoreboard), 64'(e.psb));
            chk("err", 64'(sbif.sb2d_err), 64'(e.err));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      model_clear();
      do_reset();
      // r7 issued, retired three cycles later
      iss_r(7); idle(); idle(); ret_r(7); idle();
      // two pending r9, both ports retire r9 while a new r9 issues
      iss_r(9); iss_r(9);
      step(1'b1,1'b1,9,1'b0,0,2'b11,9,9,2'b00,0,0,1'b0);
      idle(); ret_r(9); idle();
      // predicates: p3 is the always-true slot
      iss_p(1); iss_p(3); ret_p(3); idle(); ret_p(1); idle();
      // flush beats a simultaneous issue and retire
      iss_r(1); iss_r(2); iss_p(0);
      step(1'b1,1'b1,4,1'b0,0,2'b01,1,0,2'b00,0,0,1'b1);
      idle();
      // saturation, full lookahead, forced overflow, then drain
      iss_r(3); iss_r(3); iss_r(3);
      step(1'b0,1'b1,3,1'b0,0,2'b00,0,0,2'b00,0,0,1'b0);
      iss_r(3);
      ret_r(3); ret_r(3); ret_r(3); idle();
      // randomized blocks, each starting from a reset
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int i = 0; i < 100; i++) begin
            int rn, pn, w0, w1, p0, p1;
            logic iss, rwe, pwe, fl;
            logic [1:0] wv, pv;
            rn  = $urandom_range(0, 7);
            pn  = $urandom_range(0, 3);
            rwe = 1'($urandom_range(0, 1));
            pwe = 1'($urandom_range(0, 3) == 0);
            iss = 1'($urandom_range(0, 1));
            if (rwe && rc[rn] == MAXC && $urandom_range(0, 7) != 0) iss = 1'b0;
            w0 = $urandom_range(0, 7); w1 = $urandom_range(0, 7);
            p0 = $urandom_range(0, 3); p1 = $urandom_range(0, 3);
            wv[0] = ($urandom_range(0, 2) != 0) && (rc[w0] > 0 || $urandom_range(0, 15) == 0);
            wv[1] = ($urandom_range(0, 2) != 0) && (rc[w1] > 0 || $urandom_range(0, 15) == 0);
            pv[0] = (p0 < NPREDS) ? (pc[p0 % NPREDS] > 0) : ($urandom_range(0, 1) == 0);
            pv[1] = 1'b0;
            fl  = 1'($urandom_range(0, 39) == 0);
            step(iss, rwe, rn, pwe, pn, wv, w0, w1, pv, p0, p1, fl);
         end
      end
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
